baud_gen_frac: RTL and testbench

- Parametrised UART baud-tick generator: independent TX and RX prescalers with a runtime-programmable integer+fractional divisor and configurable oversampling ratio.
- Produces single-cycle strobes: `rx_tick` (oversample rate), `rx_mid` (bit-centre sample point) and `tx_tick` (bit rate).
- Sits between the system clock domain and the UART TX/RX engines. The RX phase can be re-aligned to a detected start edge.

---
 rtl/baud_gen_frac.sv | 164 ++++++++++++++++
 tb/tb_baud_gen_frac.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// +------------------------------------------------------------------------+
// | baud_gen_frac : UART TX/RX baud-tick generator, integer+frac divisor    |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module baud_gen_frac_presc #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [DIV_W-1:0]  div_eff,
  input  logic [FRAC_W-1:0] frac,
  output logic              wrap
);
  logic [DIV_W:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;
  logic [DIV_W:0]    period;

  // The carry out of the accumulator stretches this interval by one clock.
  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, frac};
    period = {1'b0, div_eff} + {{DIV_W{1'b0}}, sum[FRAC_W]};
    wrap   = enable && !clear && (cnt_q == period - (DIV_W+1)'(1));
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    if (clear) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
      acc_d = sum[FRAC_W-1:0];
    end else if (enable) begin
      cnt_d = cnt_q + (DIV_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end
endmodule

module baud_gen_frac #(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OSR          = 16,
  parameter int DEFAULT_DIV  = 130,
  parameter int DEFAULT_FRAC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              rx_resync,
  output logic              rx_tick,
  output logic              rx_mid,
  output logic              tx_tick
);
  localparam int PH_W = $clog2(OSR);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PH_PRE_MID = PH_W'(OSR / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

  logic [DIV_W-1:0]  div_q, div_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [DIV_W-1:0]  div_eff;
  logic [PH_W-1:0]   tx_phase_q, tx_phase_d;
  logic [PH_W-1:0]   rx_phase_q, rx_phase_d;
  logic              tx_tick_q, tx_tick_d;
  logic              rx_tick_q, rx_tick_d;
  logic              rx_mid_q, rx_mid_d;
  logic              rx_clear;
  logic              tx_wrap, rx_wrap;

  always_comb begin
    div_d  = cfg_load ? div_int : div_q;
    frac_d = cfg_load ? div_frac : frac_q;
    // Divisors below 2 would leave no room for a low cycle between ticks.
    div_eff  = (div_q < DIV_MIN) ? DIV_MIN : div_q;
    rx_clear = cfg_load || rx_resync;
  end

  baud_gen_frac_presc #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_tx_presc (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .clear   (cfg_load),
    .div_eff (div_eff),
    .frac    (frac_q),
    .wrap    (tx_wrap)
  );

  baud_gen_frac_presc #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_rx_presc (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .clear   (rx_clear),
    .div_eff (div_eff),
    .frac    (frac_q),
    .wrap    (rx_wrap)
  );

  always_comb begin
    tx_phase_d = tx_phase_q;
    tx_tick_d  = 1'b0;
    if (cfg_load) begin
      tx_phase_d = '0;
    end else if (tx_wrap) begin
      tx_tick_d  = (tx_phase_q == PH_LAST);
      tx_phase_d = (tx_phase_q == PH_LAST) ? '0 : tx_phase_q + PH_W'(1);
    end
  end

  always_comb begin
    rx_phase_d = rx_phase_q;
    rx_tick_d  = 1'b0;
    rx_mid_d   = 1'b0;
    if (rx_clear) begin
      rx_phase_d = '0;
    end else if (rx_wrap) begin
      rx_tick_d  = 1'b1;
      rx_mid_d   = (rx_phase_q == PH_PRE_MID);
      rx_phase_d = (rx_phase_q == PH_LAST) ? '0 : rx_phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= DIV_W'(DEFAULT_DIV);
      frac_q     <= FRAC_W'(DEFAULT_FRAC);
      tx_phase_q <= '0;
      rx_phase_q <= '0;
      tx_tick_q  <= 1'b0;
      rx_tick_q  <= 1'b0;
      rx_mid_q   <= 1'b0;
    end else begin
      div_q      <= div_d;
      frac_q     <= frac_d;
      tx_phase_q <= tx_phase_d;
      rx_phase_q <= rx_phase_d;
      tx_tick_q  <= tx_tick_d;
      rx_tick_q  <= rx_tick_d;
      rx_mid_q   <= rx_mid_d;
    end
  end

  assign rx_tick = rx_tick_q;
  assign rx_mid  = rx_mid_q;
  assign tx_tick = tx_tick_q;
endmodule

`default_nettype wire

// File: tb/tb_baud_gen_frac.sv
// +------------------------------------------------------------------------+
// | tb_baud_gen_frac : directed self-checking bench for baud_gen_frac      |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_baud_gen_frac;
  logic        clk = 1'b0;
  logic        reset, enable, cfg_load, rx_resync;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        rx_tick, rx_mid, tx_tick;

  int total = 0;
  int bad   = 0;
  int rx_q[$];
  int mid_q[$];
  int tx_q[$];
  int width_err;

  baud_gen_frac #(
    .DIV_W(16), .FRAC_W(4), .OSR(16), .DEFAULT_DIV(130), .DEFAULT_FRAC(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cfg_load  (cfg_load),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .rx_resync (rx_resync),
    .rx_tick   (rx_tick),
    .rx_mid    (rx_mid),
    .tx_tick   (tx_tick)
  );

  always #5 clk = ~clk;

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Records pulse times (cycle index from 0) while driving per-cycle inputs.
  task automatic run_cycles(input int n, input int resync_at, input int off_lo, input int off_hi);
    logic p_rx, p_mid, p_tx;
    rx_q.delete();
    mid_q.delete();
    tx_q.delete();
    width_err = 0;
    p_rx = 1'b0;
    p_mid = 1'b0;
    p_tx = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (rx_tick) rx_q.push_back(c);
      if (rx_mid)  mid_q.push_back(c);
      if (tx_tick) tx_q.push_back(c);
      if ((rx_tick && p_rx) || (rx_mid && p_mid) || (tx_tick && p_tx)) width_err++;
      p_rx = rx_tick;
      p_mid = rx_mid;
      p_tx = tx_tick;
      rx_resync = (c == resync_at);
      enable = !(c >= off_lo && c <= off_hi);
      @(negedge clk);
    end
    rx_resync = 1'b0;
    enable = 1'b1;
  endtask

  task automatic do_cfg(input logic [15:0] d, input logic [3:0] f);
    div_int = d;
    div_frac = f;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    enable = 1'b0;
    cfg_load = 1'b0;
    rx_resync = 1'b0;
    div_int = '0;
    div_frac = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total++; if (rx_tick !== 1'b0) begin bad++; $display("FAIL reset_rx_tick got %b want 0", rx_tick); end
    total++; if (rx_mid !== 1'b0) begin bad++; $display("FAIL reset_rx_mid got %b want 0", rx_mid); end
    total++; if (tx_tick !== 1'b0) begin bad++; $display("FAIL reset_tx_tick got %b want 0", tx_tick); end
  endtask

  task automatic test_integer;
    enable = 1'b1;
    do_cfg(16'd130, 4'd0);
    run_cycles(4200, -1, -1, -1);
    total++; if (rx_q.size() !== 32) begin bad++; $display("FAIL int_rx_count got %0d want 32", rx_q.size()); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (q_at(rx_q, i) !== 130 * (i + 1)) begin
        bad++; $display("FAIL int_rx_time[%0d] got %0d want %0d", i, q_at(rx_q, i), 130 * (i + 1));
      end
    end
    total++; if (mid_q.size() !== 2) begin bad++; $display("FAIL int_mid_count got %0d want 2", mid_q.size()); end
    total++; if (q_at(mid_q, 0) !== 1040) begin bad++; $display("FAIL int_mid0 got %0d want 1040", q_at(mid_q, 0)); end
    total++; if (q_at(mid_q, 1) !== 3120) begin bad++; $display("FAIL int_mid1 got %0d want 3120", q_at(mid_q, 1)); end
    total++; if (tx_q.size() !== 2) begin bad++; $display("FAIL int_tx_count got %0d want 2", tx_q.size()); end
    total++; if (q_at(tx_q, 0) !== 2080) begin bad++; $display("FAIL int_tx0 got %0d want 2080", q_at(tx_q, 0)); end
    total++; if (q_at(tx_q, 1) !== 4160) begin bad++; $display("FAIL int_tx1 got %0d want 4160", q_at(tx_q, 1)); end
    total++; if (width_err !== 0) begin bad++; $display("FAIL int_pulse_width got %0d want 0", width_err); end
  endtask

  task automatic test_frac;
    int prev;
    do_cfg(16'd10, 4'd8);
    run_cycles(400, -1, -1, -1);
    total++; if (rx_q.size() !== 38) begin bad++; $display("FAIL frac_rx_count got %0d want 38", rx_q.size()); end
    prev = 0;
    for (int i = 0; i < 38; i++) begin
      total++;
      if (q_at(rx_q, i) - prev !== ((i % 2 == 0) ? 10 : 11)) begin
        bad++; $display("FAIL frac_interval[%0d] got %0d want %0d", i, q_at(rx_q, i) - prev, (i % 2 == 0) ? 10 : 11);
      end
      prev = q_at(rx_q, i);
    end
    total++; if (q_at(mid_q, 0) !== 84) begin bad++; $display("FAIL frac_mid0 got %0d want 84", q_at(mid_q, 0)); end
    total++; if (q_at(tx_q, 0) !== 168) begin bad++; $display("FAIL frac_tx0 got %0d want 168", q_at(tx_q, 0)); end
    total++; if (q_at(tx_q, 1) !== 336) begin bad++; $display("FAIL frac_tx1 got %0d want 336", q_at(tx_q, 1)); end
  endtask

  task automatic test_resync;
    do_cfg(16'd10, 4'd0);
    run_cycles(340, 37, -1, -1);
    total++; if (q_at(rx_q, 2) !== 30) begin bad++; $display("FAIL rs_rx_before got %0d want 30", q_at(rx_q, 2)); end
    total++; if (q_at(rx_q, 3) !== 48) begin bad++; $display("FAIL rs_rx_first got %0d want 48", q_at(rx_q, 3)); end
    total++; if (q_at(rx_q, 4) !== 58) begin bad++; $display("FAIL rs_rx_second got %0d want 58", q_at(rx_q, 4)); end
    total++; if (rx_q.size() !== 33) begin bad++; $display("FAIL rs_rx_count got %0d want 33", rx_q.size()); end
    total++; if (q_at(mid_q, 0) !== 118) begin bad++; $display("FAIL rs_mid0 got %0d want 118", q_at(mid_q, 0)); end
    total++; if (q_at(mid_q, 1) !== 278) begin bad++; $display("FAIL rs_mid1 got %0d want 278", q_at(mid_q, 1)); end
    total++; if (q_at(tx_q, 0) !== 160) begin bad++; $display("FAIL rs_tx0 got %0d want 160", q_at(tx_q, 0)); end
    total++; if (q_at(tx_q, 1) !== 320) begin bad++; $display("FAIL rs_tx1 got %0d want 320", q_at(tx_q, 1)); end
  endtask

  task automatic test_clamp;
    for (int d = 0; d < 2; d++) begin
      do_cfg(16'(d), 4'd0);
      run_cycles(70, -1, -1, -1);
      total++; if (rx_q.size() !== 34) begin bad++; $display("FAIL clamp%0d_rx_count got %0d want 34", d, rx_q.size()); end
      total++; if (q_at(rx_q, 0) !== 2) begin bad++; $display("FAIL clamp%0d_rx0 got %0d want 2", d, q_at(rx_q, 0)); end
      total++; if (q_at(rx_q, 33) !== 68) begin bad++; $display("FAIL clamp%0d_rx33 got %0d want 68", d, q_at(rx_q, 33)); end
      total++; if (q_at(tx_q, 0) !== 32) begin bad++; $display("FAIL clamp%0d_tx0 got %0d want 32", d, q_at(tx_q, 0)); end
      total++; if (q_at(tx_q, 1) !== 64) begin bad++; $display("FAIL clamp%0d_tx1 got %0d want 64", d, q_at(tx_q, 1)); end
      total++; if (width_err !== 0) begin bad++; $display("FAIL clamp%0d_pulse_width got %0d want 0", d, width_err); end
    end
  endtask

  task automatic test_enable;
    do_cfg(16'd10, 4'd0);
    run_cycles(110, -1, 34, 83);
    total++; if (rx_q.size() !== 5) begin bad++; $display("FAIL en_rx_count got %0d want 5", rx_q.size()); end
    total++; if (q_at(rx_q, 2) !== 30) begin bad++; $display("FAIL en_rx_before got %0d want 30", q_at(rx_q, 2)); end
    total++; if (q_at(rx_q, 3) !== 90) begin bad++; $display("FAIL en_rx_resume got %0d want 90", q_at(rx_q, 3)); end
    total++; if (q_at(rx_q, 4) !== 100) begin bad++; $display("FAIL en_rx_next got %0d want 100", q_at(rx_q, 4)); end
  endtask

  task automatic test_reset_mid;
    int exp_rx[11] = '{130, 260, 390, 520, 650, 781, 911, 1041, 1171, 1301, 1432};
    do_cfg(16'd20, 4'd0);
    run_cycles(59, -1, -1, -1);
    reset = 1'b1;
    cfg_load = 1'b1;
    div_int = 16'd20;
    @(negedge clk);
    reset = 1'b0;
    cfg_load = 1'b0;
    total++; if (rx_tick !== 1'b0) begin bad++; $display("FAIL rst_mid_rx_tick got %b want 0", rx_tick); end
    total++; if (rx_mid !== 1'b0) begin bad++; $display("FAIL rst_mid_rx_mid got %b want 0", rx_mid); end
    total++; if (tx_tick !== 1'b0) begin bad++; $display("FAIL rst_mid_tx_tick got %b want 0", tx_tick); end
    run_cycles(1450, -1, -1, -1);
    total++; if (rx_q.size() !== 11) begin bad++; $display("FAIL rst_rx_count got %0d want 11", rx_q.size()); end
    for (int i = 0; i < 11; i++) begin
      total++;
      if (q_at(rx_q, i) !== exp_rx[i]) begin
        bad++; $display("FAIL rst_rx_time[%0d] got %0d want %0d", i, q_at(rx_q, i), exp_rx[i]);
      end
    end
    total++; if (q_at(mid_q, 0) !== 1041) begin bad++; $display("FAIL rst_mid0 got %0d want 1041", q_at(mid_q, 0)); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_integer();
    test_frac();
    test_resync();
    test_clamp();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
